// File: rtl/lo_nco_pkg.sv
// lo_nco_pkg: widths, CORDIC constants, pipeline word and helpers for lo_nco.
// LFSR constants exist only when LO_NCO_DITHER_EN is defined.
package lo_nco_pkg;

  localparam int unsigned XY_W    = 18;
  localparam int unsigned Z_W     = 20;
  localparam int unsigned N_STAGE = 16;
  localparam int unsigned LATENCY = 18;

  localparam logic signed [XY_W-1:0] X0 = 18'sd19432;

  // round(atan(2^-i) * 2^20 / 2pi); 2^20 is one full turn
  localparam logic signed [Z_W-1:0] ATAN [0:N_STAGE-1] = '{
    20'sd131072, 20'sd77376, 20'sd40884, 20'sd20753,
    20'sd10417,  20'sd5213,  20'sd2607,  20'sd1304,
    20'sd652,    20'sd326,   20'sd163,   20'sd81,
    20'sd41,     20'sd20,    20'sd10,    20'sd5
  };

  typedef struct packed {
    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic signed [Z_W-1:0]  z;
    logic                   neg;
  } cordic_t;

  // Clamp to the symmetric 16-bit range +/-32767
  function automatic logic signed [15:0] sat16(input logic signed [XY_W:0] v);
    if (v > 19'sd32767)       return 16'sd32767;
    else if (v < -19'sd32767) return -16'sd32767;
    else                      return v[15:0];
  endfunction

`ifdef LO_NCO_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
`endif

endpackage

// File: rtl/lo_nco_if.sv
// lo_nco_if: control inputs from the register domain and the LO outputs.
interface lo_nco_if;
  logic [31:0]        fw_in;
  logic               fw_load;
  logic [15:0]        phase_ofs;
  logic               phase_clr;
  logic               nco_enb;
  logic signed [15:0] lo_cos;
  logic signed [15:0] lo_sin;
  logic               lo_valid;

  modport master (
    output fw_in, fw_load, phase_ofs, phase_clr, nco_enb,
    input  lo_cos, lo_sin, lo_valid
  );

  modport slave (
    input  fw_in, fw_load, phase_ofs, phase_clr, nco_enb,
    output lo_cos, lo_sin, lo_valid
  );
endinterface

// File: rtl/lo_nco_cordic_stage.sv
// lo_nco_cordic_stage: one registered CORDIC micro-rotation by +/-atan(2^-I).
module lo_nco_cordic_stage
  import lo_nco_pkg::*;
#(
  parameter int unsigned I = 0
) (
  input  logic    clk_25d6m,
  input  logic    rst_n,
  input  cordic_t stage_i,
  output cordic_t stage_o
);

  logic signed [XY_W-1:0] x_sh;
  logic signed [XY_W-1:0] y_sh;
  cordic_t                stage_d;
  cordic_t                stage_q;

  // Rotate toward z = 0; the quadrant-fold flag rides along untouched
  always_comb begin
    x_sh    = $signed(stage_i.x) >>> I;
    y_sh    = $signed(stage_i.y) >>> I;
    stage_d = stage_i;
    if (stage_i.z[Z_W-1]) begin
      stage_d.x = stage_i.x + y_sh;
      stage_d.y = stage_i.y - x_sh;
      stage_d.z = stage_i.z + ATAN[I];
    end else begin
      stage_d.x = stage_i.x - y_sh;
      stage_d.y = stage_i.y + x_sh;
      stage_d.z = stage_i.z - ATAN[I];
    end
  end

  // Pipeline register
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/lo_nco.sv
// lo_nco: phase accumulator + offset + quadrant fold + 16-stage CORDIC,
// producing lo_cos/lo_sin 18 cycles after the accumulator value.
// Optional feature: LO_NCO_DITHER_EN adds LFSR dither to the phase ahead of
// the offset add; undefined gives bit-exact deterministic outputs.
module lo_nco
  import lo_nco_pkg::*;
#(
  parameter logic [31:0] FW_DEFAULT = 32'd0
) (
  input logic      clk_25d6m,
  input logic      rst_n,
  lo_nco_if.slave  bus
);

  logic [31:0]          fw_q;
  logic [31:0]          acc_q;
  logic [31:0]          acc_d;
  logic [15:0]          phase_src;
  logic [15:0]          p;
  logic [15:0]          z16;
  cordic_t              s0_d;
  cordic_t              s0_q;
  cordic_t              pipe [0:N_STAGE];
  logic signed [XY_W:0] x_ext;
  logic signed [XY_W:0] y_ext;
  logic signed [XY_W:0] x_fin;
  logic signed [XY_W:0] y_fin;
  logic signed [15:0]   cos_d;
  logic signed [15:0]   cos_q;
  logic signed [15:0]   sin_d;
  logic signed [15:0]   sin_q;
  logic [LATENCY-1:0]   valid_q;

  // Frequency word register
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n)           fw_q <= FW_DEFAULT;
    else if (bus.fw_load) fw_q <= bus.fw_in;
  end

  // Accumulator next state: clear has priority over advance
  always_comb begin
    acc_d = acc_q;
    if (bus.phase_clr)    acc_d = '0;
    else if (bus.nco_enb) acc_d = acc_q + fw_q;
  end

  // Accumulator register
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef LO_NCO_DITHER_EN
  logic [15:0] lfsr_q;
  logic [31:0] acc_dith;

  // Free-running dither LFSR
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign acc_dith  = acc_q + {16'b0, lfsr_q[15:12], 12'b0};
  assign phase_src = acc_dith[31:16];
`else
  assign phase_src = acc_q[31:16];
`endif

  // Stage 0: add offset, fold quadrants 2/3 onto 1/4 by a half-turn plus sign flag
  always_comb begin
    p        = phase_src + bus.phase_ofs;
    s0_d     = '0;
    s0_d.neg = p[15] ^ p[14];
    z16      = s0_d.neg ? (p - 16'h8000) : p;
    s0_d.x   = X0;
    s0_d.y   = '0;
    s0_d.z   = {z16, 4'b0000};
  end

  // Stage 0 register
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) s0_q <= '0;
    else        s0_q <= s0_d;
  end

  assign pipe[0] = s0_q;

  for (genvar g = 0; g < N_STAGE; g++) begin : g_stage
    lo_nco_cordic_stage #(.I(g)) u_stage (
      .clk_25d6m (clk_25d6m),
      .rst_n     (rst_n),
      .stage_i   (pipe[g]),
      .stage_o   (pipe[g+1])
    );
  end

  // Output stage: undo the fold, then saturate (one extra bit so negation cannot wrap)
  always_comb begin
    x_ext = {pipe[N_STAGE].x[XY_W-1], pipe[N_STAGE].x};
    y_ext = {pipe[N_STAGE].y[XY_W-1], pipe[N_STAGE].y};
    x_fin = pipe[N_STAGE].neg ? -x_ext : x_ext;
    y_fin = pipe[N_STAGE].neg ? -y_ext : y_ext;
    cos_d = sat16(x_fin);
    sin_d = sat16(y_fin);
  end

  // Output registers
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  // Valid fills with ones once per cycle after reset, independent of nco_enb
  always_ff @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= {valid_q[LATENCY-2:0], 1'b1};
  end

  assign bus.lo_cos   = cos_q;
  assign bus.lo_sin   = sin_q;
  assign bus.lo_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_lo_nco.sv
// tb_lo_nco: randomized self-checking bench for lo_nco against a trig reference.
`timescale 1ns/1ps
module tb_lo_nco;

  localparam logic [31:0] FW_DEF = 32'h0123_4567;
  localparam int  TOL_Q  = 4;    // exact quadrant angles
  localparam int  TOL_G  = 24;   // arbitrary angles, CORDIC truncation allowance
  localparam real AMP    = 32000.0;
  localparam real TWO_PI = 6.283185307179586;

  logic clk_25d6m = 1'b0;
  logic rst_n     = 1'b0;

  lo_nco_if bus ();

  lo_nco #(.FW_DEFAULT(FW_DEF)) dut (
    .clk_25d6m (clk_25d6m),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_25d6m = ~clk_25d6m;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: accumulator arithmetic plus history of sampled phases by edge number
  logic [31:0] m_acc = '0;
  logic [31:0] m_fw  = FW_DEF;
  int unsigned m_cyc = 0;
  logic [15:0] m_ph [0:31];

  always @(posedge clk_25d6m or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = '0;
      m_fw  = FW_DEF;
      m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      m_ph[m_cyc % 32] = m_acc[31:16] + bus.phase_ofs;
      if (bus.phase_clr)    m_acc = '0;
      else if (bus.nco_enb) m_acc = m_acc + m_fw;
      if (bus.fw_load)      m_fw = bus.fw_in;
    end
  end

  function automatic int ref_cos(input logic [15:0] ph);
    return int'(AMP * $cos(TWO_PI * real'(ph) / 65536.0));
  endfunction

  function automatic int ref_sin(input logic [15:0] ph);
    return int'(AMP * $sin(TWO_PI * real'(ph) / 65536.0));
  endfunction

  // Expected outputs after the latest edge; the pipeline is all zeros before the 18th edge
  function automatic int exp_cos_now();
    if (m_cyc < 18) return 0;
    return ref_cos(m_ph[(m_cyc - 17) % 32]);
  endfunction

  function automatic int exp_sin_now();
    if (m_cyc < 18) return 0;
    return ref_sin(m_ph[(m_cyc - 17) % 32]);
  endfunction

  function automatic logic exp_valid_now();
    return (m_cyc >= 18);
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_25d6m);
  endtask

  task automatic test_reset();
    int c, s;
    bus.fw_in = '0; bus.fw_load = 1'b0; bus.phase_ofs = '0;
    bus.phase_clr = 1'b0; bus.nco_enb = 1'b0;
    rst_n = 1'b0;
    wait_neg(3);
    n_cmp++; if (bus.lo_cos !== 16'sd0)  begin n_bad++; $display("FAIL rst_cos: got %0d expected 0", bus.lo_cos); end
    n_cmp++; if (bus.lo_sin !== 16'sd0)  begin n_bad++; $display("FAIL rst_sin: got %0d expected 0", bus.lo_sin); end
    n_cmp++; if (bus.lo_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b expected 0", bus.lo_valid); end
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      if (k == 17) begin
        n_cmp++; if (bus.lo_valid !== 1'b0) begin n_bad++; $display("FAIL valid_edge17: got %b expected 0", bus.lo_valid); end
        n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL cos_edge17: got %0d expected 0", c); end
      end
      if (k == 18) begin
        n_cmp++; if (bus.lo_valid !== 1'b1) begin n_bad++; $display("FAIL valid_edge18: got %b expected 1", bus.lo_valid); end
        n_cmp++; if (c > 32000 + TOL_Q || c < 32000 - TOL_Q) begin n_bad++; $display("FAIL cos_0deg: got %0d expected 32000+/-%0d", c, TOL_Q); end
        n_cmp++; if (s > TOL_Q || s < -TOL_Q) begin n_bad++; $display("FAIL sin_0deg: got %0d expected 0+/-%0d", s, TOL_Q); end
      end
    end
  endtask

  task automatic test_phase_ofs();
    logic [15:0] ofs_tab [0:3];
    int c, s, ec, es, oc, os;
    ofs_tab[0] = 16'h4000; ofs_tab[1] = 16'h8000; ofs_tab[2] = 16'hC000; ofs_tab[3] = 16'h0000;
    for (int t = 0; t < 4; t++) begin
      oc = int'(bus.lo_cos); os = int'(bus.lo_sin);
      bus.phase_ofs = ofs_tab[t];
      ec = ref_cos(ofs_tab[t]); es = ref_sin(ofs_tab[t]);
      wait_neg(17);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      n_cmp++; if (c !== oc || s !== os) begin n_bad++; $display("FAIL ofs_early[%0d]: got %0d/%0d expected %0d/%0d", t, c, s, oc, os); end
      wait_neg(1);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      n_cmp++; if (c > ec + TOL_Q || c < ec - TOL_Q) begin n_bad++; $display("FAIL ofs_cos[%0d]: got %0d expected %0d+/-%0d", t, c, ec, TOL_Q); end
      n_cmp++; if (s > es + TOL_Q || s < es - TOL_Q) begin n_bad++; $display("FAIL ofs_sin[%0d]: got %0d expected %0d+/-%0d", t, s, es, TOL_Q); end
    end
  endtask

  task automatic test_quarter_rate();
    int c, s, ec, es;
    bus.fw_in = 32'h4000_0000; bus.fw_load = 1'b1; bus.phase_clr = 1'b1; bus.nco_enb = 1'b1;
    wait_neg(1);
    bus.fw_load = 1'b0; bus.phase_clr = 1'b0;
    wait_neg(20);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      ec = exp_cos_now(); es = exp_sin_now();
      n_cmp++; if (c > ec + TOL_Q || c < ec - TOL_Q) begin n_bad++; $display("FAIL quarter_cos[%0d]: got %0d expected %0d", k, c, ec); end
      n_cmp++; if (s > es + TOL_Q || s < es - TOL_Q) begin n_bad++; $display("FAIL quarter_sin[%0d]: got %0d expected %0d", k, s, es); end
    end
  endtask

  task automatic test_clr_load_same();
    int c, s, ec, es;
    logic [31:0] fw_new;
    bus.fw_in = $urandom; bus.fw_load = 1'b1; bus.nco_enb = 1'b1; bus.phase_ofs = '0;
    wait_neg(1);
    bus.fw_load = 1'b0;
    wait_neg(30);
    fw_new = {$urandom_range(16'h0400, 16'h7FFF), 16'h1234};
    bus.fw_in = fw_new; bus.fw_load = 1'b1; bus.phase_clr = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_25d6m);
      bus.fw_load = 1'b0; bus.phase_clr = 1'b0;
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      ec = exp_cos_now(); es = exp_sin_now();
      if (k == 19) begin
        n_cmp++; if (c > 32000 + TOL_Q || c < 32000 - TOL_Q) begin n_bad++; $display("FAIL clr_cos_t19: got %0d expected 32000+/-%0d", c, TOL_Q); end
        n_cmp++; if (s > TOL_Q || s < -TOL_Q) begin n_bad++; $display("FAIL clr_sin_t19: got %0d expected 0+/-%0d", s, TOL_Q); end
      end
      n_cmp++; if (c > ec + TOL_G || c < ec - TOL_G || s > es + TOL_G || s < es - TOL_G) begin
        n_bad++; $display("FAIL clr_track[%0d]: got %0d/%0d expected %0d/%0d", k, c, s, ec, es);
      end
    end
  endtask

  task automatic test_hold();
    int c, s, ec, es;
    bus.nco_enb = 1'b0;
    bus.phase_ofs = 16'($urandom);
    wait_neg(18);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      ec = exp_cos_now(); es = exp_sin_now();
      n_cmp++; if (c > ec + TOL_G || c < ec - TOL_G || s > es + TOL_G || s < es - TOL_G) begin
        n_bad++; $display("FAIL hold[%0d]: got %0d/%0d expected %0d/%0d", k, c, s, ec, es);
      end
    end
  endtask

  task automatic test_random();
    int c, s, ec, es;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      ec = exp_cos_now(); es = exp_sin_now();
      n_cmp++; if (bus.lo_valid !== exp_valid_now()) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", k, bus.lo_valid, exp_valid_now()); end
      n_cmp++; if (c > ec + TOL_G || c < ec - TOL_G) begin n_bad++; $display("FAIL rand_cos[%0d]: got %0d expected %0d", k, c, ec); end
      n_cmp++; if (s > es + TOL_G || s < es - TOL_G) begin n_bad++; $display("FAIL rand_sin[%0d]: got %0d expected %0d", k, s, es); end
      bus.nco_enb   = ($urandom_range(0, 3) != 0);
      bus.phase_clr = ($urandom_range(0, 31) == 0);
      bus.fw_load   = ($urandom_range(0, 15) == 0);
      bus.fw_in     = $urandom;
      if ($urandom_range(0, 7) == 0) bus.phase_ofs = 16'($urandom);
    end
    bus.phase_clr = 1'b0; bus.fw_load = 1'b0;
  endtask

  task automatic test_magnitude();
    int c, s;
    longint mag, ref_mag;
    ref_mag = longint'(32000) * 32000;
    bus.fw_in = 32'd26843546; bus.fw_load = 1'b1; bus.phase_clr = 1'b1;
    bus.nco_enb = 1'b1; bus.phase_ofs = '0;
    wait_neg(1);
    bus.fw_load = 1'b0; bus.phase_clr = 1'b0;
    wait_neg(20);
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      mag = longint'(c) * c + longint'(s) * s;
      n_cmp++; if (mag > ref_mag + ref_mag / 100 || mag < ref_mag - ref_mag / 100) begin
        n_bad++; $display("FAIL mag[%0d]: got %0d expected %0d+/-1%%", k, mag, ref_mag);
      end
      n_cmp++; if (c >= 32767 || c <= -32767 || s >= 32767 || s <= -32767) begin
        n_bad++; $display("FAIL sat[%0d]: got %0d/%0d expected |v|<32767", k, c, s);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, s, ec, es;
    bus.fw_in = $urandom; bus.fw_load = 1'b1; bus.nco_enb = 1'b1; bus.phase_ofs = 16'h1357;
    wait_neg(1);
    bus.fw_load = 1'b0;
    wait_neg(25);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.lo_cos !== 16'sd0)  begin n_bad++; $display("FAIL arst_cos: got %0d expected 0", bus.lo_cos); end
    n_cmp++; if (bus.lo_sin !== 16'sd0)  begin n_bad++; $display("FAIL arst_sin: got %0d expected 0", bus.lo_sin); end
    n_cmp++; if (bus.lo_valid !== 1'b0)  begin n_bad++; $display("FAIL arst_valid: got %b expected 0", bus.lo_valid); end
    @(negedge clk_25d6m);
    bus.nco_enb = 1'b0; bus.phase_ofs = '0;
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos);
      if (k == 17) begin
        n_cmp++; if (bus.lo_valid !== 1'b0) begin n_bad++; $display("FAIL refill_valid17: got %b expected 0", bus.lo_valid); end
      end
      if (k == 18) begin
        n_cmp++; if (bus.lo_valid !== 1'b1) begin n_bad++; $display("FAIL refill_valid18: got %b expected 1", bus.lo_valid); end
        n_cmp++; if (c > 32000 + TOL_Q || c < 32000 - TOL_Q) begin n_bad++; $display("FAIL refill_cos: got %0d expected 32000+/-%0d", c, TOL_Q); end
      end
    end
    // Accumulator now advances by the reset-time default frequency word
    bus.nco_enb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_25d6m);
      c = int'(bus.lo_cos); s = int'(bus.lo_sin);
      ec = exp_cos_now(); es = exp_sin_now();
      n_cmp++; if (c > ec + TOL_G || c < ec - TOL_G || s > es + TOL_G || s < es - TOL_G) begin
        n_bad++; $display("FAIL fw_default[%0d]: got %0d/%0d expected %0d/%0d", k, c, s, ec, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_phase_ofs();
    test_quarter_rate();
    test_clr_load_same();
    test_hold();
    test_random();
    test_magnitude();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
